seq_pp_reducer: RTL and testbench
=================================

// Module: seq_pp_reducer
// PURPOSE
//  Sequential unsigned WIDTH x WIDTH multiplier that time-shares one row of 2*WIDTH exact 4:2
//  compressor cells (comp_exact) over the partial products. Each cycle it folds two new
//  partial-product rows into a carry-save accumulator. A final carry-propagate add then yields P.
//  Serves as the exact baseline and controller for the approximate-multiplier comparison flow.
// PARAMETERS
//  WIDTH  8  operand width; must be even and >= 4 (elaboration error otherwise)
// PORTS
//  CLK        in   1        rising-edge clock
//  RST_N      in   1        asynchronous active-low reset
//  IN_VALID   in   1        A/B valid
//  IN_READY   out  1        block can accept operands (high only in IDLE)
//  A          in   WIDTH    multiplicand, unsigned
//  B          in   WIDTH    multiplier, unsigned
//  OUT_VALID  out  1        P valid
//  OUT_READY  in   1        consumer accepts P
//  P          out  2*WIDTH  product A*B
//  BUSY       out  1        high in COMPRESS, FINAL, DONE
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, IN_READY=0 during reset then 1; OUT_VALID=0, P=0, BUSY=0.
//   Accumulators S,C, captured A,B and counter are cleared.
//  FSM IDLE -> COMPRESS -> FINAL -> DONE -> IDLE.
//  IDLE: IN_READY=1. On IN_VALID&IN_READY: capture A,B; S=0, C=0, cnt=0; go to COMPRESS.
//  COMPRESS (WIDTH/2 cycles, cnt=0..WIDTH/2-1):
//   - rows r0=2*cnt, r1=2*cnt+1; pp_r = B[r] ? (A<<r) : 0, zero-extended to 2*WIDTH.
//   - cell k (0..2W-1): X1=S[k], X2=C[k], X3=pp_r0[k], X4=pp_r1[k], Cin=Cout of cell k-1.
//     Cell 0 has Cin=0.
//   - next S[k]=Sum_k; next C[k+1]=Carry_k; next C[0]=0.
//     Carry of the top cell and Cout of the top cell are discarded (result is mod 2^(2W), exact).
//   - cnt==WIDTH/2-1 -> FINAL; otherwise cnt++.
//  FINAL (1 cycle): P <= S + C (2*WIDTH bits, overflow dropped); OUT_VALID <= 1; go to DONE.
//  DONE: P and OUT_VALID held stable while OUT_READY=0.
//   On OUT_READY: OUT_VALID <= 0, go to IDLE. P keeps its last value.
//  Latency: OUT_VALID rises WIDTH/2+1 clocks after the accepting edge (5 for WIDTH=8).
//   Throughput: one product per WIDTH/2+3 clocks minimum.
//  IN_VALID outside IDLE is ignored; operands are not queued. A/B changes after capture have no effect.
//  OUT_READY while OUT_VALID=0 has no effect.
//  Reset mid-operation aborts immediately: no OUT_VALID pulse for the aborted operand pair.
//  Invariant checked in sim: at every COMPRESS edge, S+C == sum of rows folded so far (mod 2^(2W)).
// TESTING
//  1. A=0xFF, B=0xFF, OUT_READY=1 -> OUT_VALID 5 clocks after accept, P=0xFE01, one-cycle pulse.
//  2. A=0x00, B=0xB7 and A=0xB7, B=0x00 -> P=0x0000. Also A=0x01, B=0x80 -> P=0x0080.
//  3. A=0xA5, B=0x3C, OUT_READY held 0 for 3 clocks after OUT_VALID -> P=0x26AC and OUT_VALID
//     stable throughout; IN_READY=0 until 1 clock after OUT_READY is raised.
//  4. IN_VALID pulsed with A=0x12, B=0x34 during COMPRESS of 0x0F*0x0F -> ignored; P=0x00E1 only.
//  5. RST_N low for 1 clock mid-COMPRESS -> all outputs 0, no OUT_VALID.
//     Next op 0x80*0x80 -> P=0x4000.
//  6. 10k random pairs with random OUT_READY stalls, WIDTH=8 and WIDTH=16 -> P==A*B on every handshake.

Source files
------------

// File: rtl/seq_pp_reducer.sv
// seq_pp_reducer: sequential unsigned multiplier that folds two partial-product rows per cycle
// into a carry-save accumulator through one row of exact 4:2 compressors, then adds S+C.
module comp_exact (
   input  logic x1_i,
   input  logic x2_i,
   input  logic x3_i,
   input  logic x4_i,
   input  logic cin_i,
   output logic sum_o,
   output logic carry_o,
   output logic cout_o
);
   logic s1;
   // cout depends only on x1..x3, so the cin chain never ripples more than one cell
   assign s1      = x1_i ^ x2_i ^ x3_i;
   assign cout_o  = (x1_i & x2_i) | (x1_i & x3_i) | (x2_i & x3_i);
   assign sum_o   = s1 ^ x4_i ^ cin_i;
   assign carry_o = (s1 & x4_i) | (s1 & cin_i) | (x4_i & cin_i);
endmodule

module seq_pp_reducer #(
   parameter int WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [2*WIDTH-1:0] p_o,
   output logic               busy_o
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH / 2);

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("seq_pp_reducer: WIDTH must be even and >= 4");
   end

   typedef enum logic [1:0] {IDLE, COMPRESS, FINAL, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [W2-1:0]     s_q, s_d, c_q, c_d, p_q, p_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW:0]       r0, r1;
   logic [W2-1:0]     a_ext, pp0, pp1, sum, cy, cout, cin;
   logic              last;

   assign r0    = {cnt_q, 1'b0};
   assign r1    = {cnt_q, 1'b1};
   assign a_ext = W2'(a_q);
   assign pp0   = b_q[r0] ? a_ext << r0 : '0;
   assign pp1   = b_q[r1] ? a_ext << r1 : '0;
   // top-cell carry and cout fall off the end: the product is exact modulo 2^(2W)
   assign cin   = W2'({cout, 1'b0});
   assign last  = cnt_q == CW'(WIDTH / 2 - 1);

   for (genvar k = 0; k < W2; k++) begin : g_cell
      comp_exact u_cell (
         .x1_i   (s_q[k]),
         .x2_i   (c_q[k]),
         .x3_i   (pp0[k]),
         .x4_i   (pp1[k]),
         .cin_i  (cin[k]),
         .sum_o  (sum[k]),
         .carry_o(cy[k]),
         .cout_o (cout[k])
      );
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         IDLE: if (in_valid_i) begin
            a_d     = a_i;
            b_d     = b_i;
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            state_d = COMPRESS;
         end
         COMPRESS: begin
            s_d     = sum;
            c_d     = W2'({cy, 1'b0});
            cnt_d   = last ? cnt_q : cnt_q + 1'b1;
            state_d = last ? FINAL : COMPRESS;
         end
         FINAL: begin
            p_d     = s_q + c_q;
            state_d = DONE;
         end
         default: state_d = out_ready_i ? IDLE : DONE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign in_ready_o  = rst_n_i && state_q == IDLE;
   assign out_valid_o = state_q == DONE;
   assign busy_o      = state_q != IDLE;
   assign p_o         = p_q;
endmodule

// File: tb/tb_seq_pp_reducer.sv
// tb_seq_pp_reducer: directed checks of seq_pp_reducer (WIDTH=8) against hand-computed products,
// latency, stall holding, ignored mid-operation inputs and asynchronous abort.
module tb_seq_pp_reducer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] p;
   logic        busy;
   int          checks = 0;
   int          errors = 0;

   seq_pp_reducer #(.WIDTH(8)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .a_i        (a),
      .b_i        (b),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .p_o        (p),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp,
                         input int stall, input bit mid);
      int n;
      @(negedge clk);
      chk("in_ready_idle", {31'b0, in_ready}, 1);
      in_valid  = 1'b1;
      a         = ta;
      b         = tb;
      out_ready = (stall == 0);
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~ta;
      b        = ~tb;
      chk("busy_after_accept", {31'b0, busy}, 1);
      chk("in_ready_busy", {31'b0, in_ready}, 0);
      n = 0;
      while (!out_valid && n < 20) begin
         if (mid && n == 2) begin
            in_valid = 1'b1;
            a        = 8'h12;
            b        = 8'h34;
         end else in_valid = 1'b0;
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      chk("latency", n, 5);
      chk("product", {16'b0, p}, {16'b0, exp});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'b0, out_valid}, 1);
         chk("stall_p", {16'b0, p}, {16'b0, exp});
         chk("stall_in_ready", {31'b0, in_ready}, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("valid_drop", {31'b0, out_valid}, 0);
      chk("in_ready_back", {31'b0, in_ready}, 1);
      chk("p_kept", {16'b0, p}, {16'b0, exp});
      out_ready = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_p", {16'b0, p}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 1);

      run_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0);
      chk("busy_idle", {31'b0, busy}, 0);
      run_op(8'h00, 8'hB7, 16'h0000, 0, 1'b0);
      run_op(8'hB7, 8'h00, 16'h0000, 0, 1'b0);
      run_op(8'h01, 8'h80, 16'h0080, 0, 1'b0);
      run_op(8'hA5, 8'h3C, 16'h26AC, 3, 1'b0);
      run_op(8'h0F, 8'h0F, 16'h00E1, 0, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("no_ghost_op", {31'b0, busy}, 0);
      end
      run_op(8'h12, 8'h34, 16'h03A8, 1, 1'b0);
      run_op(8'hAA, 8'h55, 16'h3872, 0, 1'b0);
      run_op(8'h7F, 8'h81, 16'h3FFF, 2, 1'b0);
      run_op(8'hFF, 8'h01, 16'h00FF, 0, 1'b0);
      run_op(8'h03, 8'hFE, 16'h02FA, 0, 1'b0);
      run_op(8'hC8, 8'h64, 16'h4E20, 1, 1'b0);

      @(negedge clk);
      in_valid = 1'b1;
      a        = 8'h55;
      b        = 8'h55;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", {31'b0, out_valid}, 0);
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_in_ready", {31'b0, in_ready}, 0);
      chk("abort_p", {16'b0, p}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_no_valid", {31'b0, out_valid}, 0);
      end
      run_op(8'h80, 8'h80, 16'h4000, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
